// File: rtl/cacheline_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single cacheline memory port.
// One outstanding memory transaction at a time, with sticky timeout and protocol error flags.
module cacheline_mem_arbiter #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  r0_addr,
   input  logic         r0_read,
   input  logic         r0_write,
   input  logic [255:0] r0_wdata,
   output logic [255:0] r0_rdata,
   output logic         r0_resp,
   input  logic [31:0]  r1_addr,
   input  logic         r1_read,
   input  logic         r1_write,
   input  logic [255:0] r1_wdata,
   output logic [255:0] r1_rdata,
   output logic         r1_resp,
   output logic [31:0]  mem_addr,
   output logic         mem_read,
   output logic         mem_write,
   output logic [255:0] mem_wdata,
   input  logic [255:0] mem_rdata,
   input  logic         mem_resp,
   output logic         timeout_err,
   output logic         proto_err
);

   // state | meaning
   // IDLE  | no transaction outstanding; arbitrate pending requesters
   // BUSY  | memory request of requester 'grant' outstanding, waiting for mem_resp
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [9:0] TMAX = 10'(TIMEOUT);

   state_t      state;
   logic        grant;
   logic        last_grant;
   logic [9:0]  tcount;

   logic        pend0, pend1, bad0, bad1, pick;
   logic        unused_addr_bits;

   // Read and write together is not a legal request and is never arbitrated.
   assign pend0 = r0_read ^ r0_write;
   assign pend1 = r1_read ^ r1_write;
   assign bad0  = r0_read & r0_write;
   assign bad1  = r1_read & r1_write;
   assign pick  = (pend0 && pend1) ? ~last_grant : pend1;

   assign unused_addr_bits = ^{r0_addr[4:0], r1_addr[4:0]};

   assign r0_rdata = mem_rdata;
   assign r1_rdata = mem_rdata;
   assign r0_resp  = (state == BUSY) && !grant && mem_resp;
   assign r1_resp  = (state == BUSY) &&  grant && mem_resp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         tcount      <= '0;
         mem_addr    <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_wdata   <= '0;
         timeout_err <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bad0 || bad1) proto_err <= 1'b1;
               if (pend0 || pend1) begin
                  state      <= BUSY;
                  grant      <= pick;
                  last_grant <= pick;
                  tcount     <= '0;
                  if (pick) begin
                     mem_addr  <= {r1_addr[31:5], 5'b0};
                     mem_read  <= r1_read;
                     mem_write <= r1_write;
                     mem_wdata <= r1_wdata;
                  end else begin
                     mem_addr  <= {r0_addr[31:5], 5'b0};
                     mem_read  <= r0_read;
                     mem_write <= r0_write;
                     mem_wdata <= r0_wdata;
                  end
               end
            end
            BUSY: begin
               if (mem_resp) begin
                  state     <= IDLE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  tcount    <= '0;
               end else if (tcount != TMAX) begin
                  tcount <= tcount + 10'd1;
                  if (tcount + 10'd1 == TMAX) timeout_err <= 1'b1;
               end else begin
                  timeout_err <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter with a behavioural line memory
// whose response delay can be set or held off entirely.
module tb_cacheline_mem_arbiter;

   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  r0_addr, r1_addr;
   logic         r0_read, r0_write, r1_read, r1_write;
   logic [255:0] r0_wdata, r1_wdata;
   logic [255:0] r0_rdata, r1_rdata;
   logic         r0_resp, r1_resp;
   logic [31:0]  mem_addr;
   logic         mem_read, mem_write;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata = '0;
   logic         mem_resp;
   logic         timeout_err, proto_err;

   int checks = 0;
   int fails  = 0;
   int r0_cnt = 0;
   int r1_cnt = 0;
   int both_cnt = 0;

   logic [255:0] mem [logic [31:0]];
   int   mem_delay = 2;
   bit   mem_hold  = 1'b0;
   int   mcnt      = 0;
   logic mem_resp_m     = 1'b0;
   logic mem_resp_force = 1'b0;

   assign mem_resp = mem_resp_m | mem_resp_force;

   cacheline_mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .r0_addr(r0_addr), .r0_read(r0_read), .r0_write(r0_write), .r0_wdata(r0_wdata),
      .r0_rdata(r0_rdata), .r0_resp(r0_resp),
      .r1_addr(r1_addr), .r1_read(r1_read), .r1_write(r1_write), .r1_wdata(r1_wdata),
      .r1_rdata(r1_rdata), .r1_resp(r1_resp),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .timeout_err(timeout_err), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   // Memory answers mem_delay cycles after the request appears; mem_hold stalls it.
   always @(posedge clk) begin
      #1;
      if ((mem_read || mem_write) && !mem_resp_m) begin
         if (!mem_hold) begin
            if (mcnt >= mem_delay - 1) begin
               mem_resp_m = 1'b1;
               mcnt = 0;
               if (mem_read) mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : '0;
               if (mem_write) mem[mem_addr] = mem_wdata;
            end else begin
               mcnt++;
            end
         end
      end else begin
         mem_resp_m = 1'b0;
         if (!(mem_read || mem_write)) mcnt = 0;
      end
   end

   always @(negedge clk) begin
      if (r0_resp === 1'b1) r0_cnt++;
      if (r1_resp === 1'b1) r1_cnt++;
      if (mem_read === 1'b1 && mem_write === 1'b1) both_cnt++;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      r0_addr = '0; r0_read = 0; r0_write = 0; r0_wdata = '0;
      r1_addr = '0; r1_read = 0; r1_write = 0; r1_wdata = '0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      mem_hold = 0;
      mem_resp_force = 0;
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      int c0, c1;
      clear_inputs();
      rst = 1;
      step();
      step();
      checks++; if (mem_read !== 1'b0) begin fails++; $display("FAIL reset_mem_read: got %b exp 0", mem_read); end
      checks++; if (mem_write !== 1'b0) begin fails++; $display("FAIL reset_mem_write: got %b exp 0", mem_write); end
      checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
      checks++; if (mem_wdata !== 256'h0) begin fails++; $display("FAIL reset_mem_wdata: got %h exp 0", mem_wdata); end
      checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b exp 0", timeout_err); end
      checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err: got %b exp 0", proto_err); end
      rst = 0;
      step();
      // memory response while idle must not reach either requester
      c0 = r0_cnt; c1 = r1_cnt;
      mem_resp_force = 1;
      #1;
      checks++; if (r0_resp !== 1'b0 || r1_resp !== 1'b0) begin fails++; $display("FAIL idle_resp: got r0=%b r1=%b exp 0 0", r0_resp, r1_resp); end
      step();
      mem_resp_force = 0;
      step();
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL idle_resp_mem: got rd=%b wr=%b exp 0 0", mem_read, mem_write); end
      checks++; if (r0_cnt != c0 || r1_cnt != c1) begin fails++; $display("FAIL idle_resp_cnt: got %0d/%0d exp %0d/%0d", r0_cnt, r1_cnt, c0, c1); end
   endtask

   task automatic test_single_read();
      bit got;
      logic [255:0] pat;
      pat = {8{32'h1234_5678}} ^ {32'h0, {7{32'hDEAD_BEEF}}};
      reset_dut();
      mem[32'h0000_1040] = pat;
      mem_delay = 10;
      r0_read = 1; r0_addr = 32'h0000_1040;
      step();
      checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin fails++; $display("FAIL single_ctrl: got rd=%b wr=%b exp 1 0", mem_read, mem_write); end
      checks++; if (mem_addr !== 32'h0000_1040) begin fails++; $display("FAIL single_addr: got %h exp 00001040", mem_addr); end
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin step(); got = r0_resp; end
      checks++; if (!got) begin fails++; $display("FAIL single_resp: got no r0_resp in 40 cycles exp pulse"); end
      checks++; if (r0_rdata !== pat) begin fails++; $display("FAIL single_rdata: got %h exp %h", r0_rdata, pat); end
      checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_1040) begin fails++; $display("FAIL single_hold: got rd=%b addr=%h exp 1 00001040", mem_read, mem_addr); end
      checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL single_timeout_flag: got %b exp 1", timeout_err); end
      r0_read = 0;
      step();
      checks++; if (mem_read !== 1'b0 || r0_resp !== 1'b0) begin fails++; $display("FAIL single_done: got rd=%b resp=%b exp 0 0", mem_read, r0_resp); end
      checks++; if (r1_cnt != 0) begin fails++; $display("FAIL single_r1_quiet: got %0d r1 pulses exp 0", r1_cnt); end
      mem_delay = 2;
   endtask

   task automatic test_tie();
      bit got;
      logic [255:0] pa, pc, wb;
      pa = {8{32'hAAAA_0001}};
      pc = {8{32'hCCCC_0003}};
      wb = {8{32'hBBBB_0002}};
      reset_dut();
      mem[32'h0000_4000] = pa;
      mem[32'h0000_6000] = pc;
      mem_delay = 2;
      r0_read = 1; r0_addr = 32'h0000_4000;
      r1_write = 1; r1_addr = 32'h0000_5000; r1_wdata = wb;
      step();
      checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_4000) begin fails++; $display("FAIL tie_first: got rd=%b addr=%h exp 1 00004000", mem_read, mem_addr); end
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin step(); got = r0_resp; end
      checks++; if (!got || r0_rdata !== pa) begin fails++; $display("FAIL tie_r0_data: got resp=%b data=%h exp 1 %h", got, r0_rdata, pa); end
      checks++; if (r1_resp !== 1'b0) begin fails++; $display("FAIL tie_r1_quiet: got %b exp 0", r1_resp); end
      r0_addr = 32'h0000_6000;
      step();
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL tie_gap1: got rd=%b wr=%b exp 0 0", mem_read, mem_write); end
      step();
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h0000_5000) begin fails++; $display("FAIL tie_second: got wr=%b rd=%b addr=%h exp 1 0 00005000", mem_write, mem_read, mem_addr); end
      checks++; if (mem_wdata !== wb) begin fails++; $display("FAIL tie_wdata: got %h exp %h", mem_wdata, wb); end
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin step(); got = r1_resp; end
      checks++; if (!got) begin fails++; $display("FAIL tie_r1_resp: got no r1_resp in 40 cycles exp pulse"); end
      r1_write = 0;
      step();
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL tie_gap2: got rd=%b wr=%b exp 0 0", mem_read, mem_write); end
      step();
      checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_6000) begin fails++; $display("FAIL tie_third: got rd=%b addr=%h exp 1 00006000", mem_read, mem_addr); end
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin step(); got = r0_resp; end
      checks++; if (!got || r0_rdata !== pc) begin fails++; $display("FAIL tie_r0_data2: got resp=%b data=%h exp 1 %h", got, r0_rdata, pc); end
      r0_read = 0;
      step();
   endtask

   task automatic test_misaligned();
      bit got;
      logic [255:0] a5;
      a5 = {8{32'hA5A5_A5A5}};
      reset_dut();
      mem_delay = 2;
      r1_write = 1; r1_addr = 32'h0000_201F; r1_wdata = a5;
      step();
      checks++; if (mem_addr !== 32'h0000_2000) begin fails++; $display("FAIL mis_addr: got %h exp 00002000", mem_addr); end
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== a5) begin fails++; $display("FAIL mis_write: got wr=%b rd=%b data=%h exp 1 0 %h", mem_write, mem_read, mem_wdata, a5); end
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin step(); got = r1_resp; end
      checks++; if (!got) begin fails++; $display("FAIL mis_wr_resp: got no r1_resp in 40 cycles exp pulse"); end
      r1_write = 0;
      step();
      r0_read = 1; r0_addr = 32'h0000_2005;
      step();
      checks++; if (mem_addr !== 32'h0000_2000 || mem_read !== 1'b1) begin fails++; $display("FAIL mis_rd_addr: got addr=%h rd=%b exp 00002000 1", mem_addr, mem_read); end
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin step(); got = r0_resp; end
      checks++; if (!got || r0_rdata !== a5) begin fails++; $display("FAIL mis_readback: got resp=%b data=%h exp 1 %h", got, r0_rdata, a5); end
      r0_read = 0;
      step();
   endtask

   task automatic test_timeout();
      bit got;
      int c0;
      reset_dut();
      mem_hold = 1;
      mem_delay = 1;
      r1_read = 1; r1_addr = 32'h0000_3000;
      step();
      step();
      step();
      step();
      checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_early: got %b exp 0 after 3 busy cycles", timeout_err); end
      step();
      checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_set: got %b exp 1 after 4 busy cycles", timeout_err); end
      for (int i = 0; i < 5; i++) step();
      checks++; if (timeout_err !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 32'h0000_3000) begin fails++; $display("FAIL to_wait: got err=%b rd=%b addr=%h exp 1 1 00003000", timeout_err, mem_read, mem_addr); end
      c0 = r0_cnt;
      mem_hold = 0;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin step(); got = r1_resp; end
      checks++; if (!got) begin fails++; $display("FAIL to_late_resp: got no r1_resp in 40 cycles exp pulse"); end
      r1_read = 0;
      step();
      checks++; if (timeout_err !== 1'b1 || mem_read !== 1'b0 || r0_cnt != c0) begin fails++; $display("FAIL to_after: got err=%b rd=%b r0pulses=%0d exp 1 0 %0d", timeout_err, mem_read, r0_cnt, c0); end
   endtask

   task automatic test_proto();
      bit got;
      logic [255:0] pd;
      pd = {8{32'h0D0D_F00D}};
      reset_dut();
      mem[32'h0000_7000] = pd;
      mem_delay = 2;
      r0_read = 1; r0_write = 1; r0_addr = 32'h0000_9000;
      r1_read = 1; r1_addr = 32'h0000_7000;
      step();
      checks++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_set: got %b exp 1", proto_err); end
      checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h0000_7000) begin fails++; $display("FAIL proto_r1_grant: got rd=%b wr=%b addr=%h exp 1 0 00007000", mem_read, mem_write, mem_addr); end
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin step(); got = r1_resp; end
      checks++; if (!got || r1_rdata !== pd) begin fails++; $display("FAIL proto_r1_data: got resp=%b data=%h exp 1 %h", got, r1_rdata, pd); end
      r1_read = 0;
      step();
      step();
      step();
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || proto_err !== 1'b1) begin fails++; $display("FAIL proto_excluded: got rd=%b wr=%b err=%b exp 0 0 1", mem_read, mem_write, proto_err); end
      r0_read = 0; r0_write = 0;
      step();
   endtask

   task automatic test_reset_busy();
      bit got;
      int c0, c1;
      logic [255:0] pf;
      pf = {8{32'hF00F_1234}};
      reset_dut();
      mem[32'h0000_8000] = pf;
      mem_hold = 1;
      r0_read = 1; r0_addr = 32'h0000_A000;
      r1_read = 1; r1_write = 1;
      step();
      checks++; if (mem_read !== 1'b1 || proto_err !== 1'b1) begin fails++; $display("FAIL rb_grant: got rd=%b err=%b exp 1 1", mem_read, proto_err); end
      step();
      step();
      c0 = r0_cnt; c1 = r1_cnt;
      rst = 1;
      clear_inputs();
      step();
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL rb_abort: got rd=%b wr=%b exp 0 0", mem_read, mem_write); end
      checks++; if (proto_err !== 1'b0 || timeout_err !== 1'b0) begin fails++; $display("FAIL rb_errs: got proto=%b to=%b exp 0 0", proto_err, timeout_err); end
      rst = 0;
      mem_hold = 0;
      mem_delay = 2;
      step();
      step();
      checks++; if (r0_cnt != c0 || r1_cnt != c1) begin fails++; $display("FAIL rb_no_resp: got %0d/%0d exp %0d/%0d", r0_cnt, r1_cnt, c0, c1); end
      r0_read = 1; r0_addr = 32'h0000_8000;
      step();
      checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_8000) begin fails++; $display("FAIL rb_new_req: got rd=%b addr=%h exp 1 00008000", mem_read, mem_addr); end
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin step(); got = r0_resp; end
      checks++; if (!got || r0_rdata !== pf) begin fails++; $display("FAIL rb_new_data: got resp=%b data=%h exp 1 %h", got, r0_rdata, pf); end
      r0_read = 0;
      step();
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      test_reset();
      test_single_read();
      test_tie();
      test_misaligned();
      test_timeout();
      test_proto();
      test_reset_busy();
      checks++; if (both_cnt != 0) begin fails++; $display("FAIL rd_wr_exclusive: got %0d cycles with both set exp 0", both_cnt); end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
